// File: rtl/bnn_pkg.sv
// Shared types, weight-map layout and Q-format constants
// for the Monte-Carlo Bayesian NN inference engine.
package bnn_pkg;

    localparam int DW   = 20;
    localparam int FRAC = 16;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE, HACC, HACT, OACC, OSIG, DRAIN
    } state_t;

    localparam logic signed [DW-1:0] SMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] ONE   = DW'(1 << FRAC);
    localparam logic signed [DW-1:0] HALF  = DW'(1 << (FRAC - 1));
    localparam logic signed [DW-1:0] SP_LO = DW'(-(2 << FRAC));
    localparam logic signed [DW-1:0] SP_HI = DW'(2 << FRAC);
    localparam logic signed [DW-1:0] SG_B1 = DW'(1 << FRAC);
    localparam logic signed [DW-1:0] SG_B2 = DW'(19 << (FRAC - 3));
    localparam logic signed [DW-1:0] SG_B3 = DW'(5 << FRAC);
    localparam logic signed [DW-1:0] SG_C2 = DW'(5 << (FRAC - 3));
    localparam logic signed [DW-1:0] SG_C3 = DW'(27 << (FRAC - 5));

    // Weight map: mean W, var W, mean bias, var bias, out W, out bias
    function automatic int mw_addr(int n_in, int h, int i);
        return h * n_in + i;
    endfunction

    function automatic int vw_addr(int n_in, int n_hid, int h, int i);
        return n_hid * n_in + h * n_in + i;
    endfunction

    function automatic int mb_addr(int n_in, int n_hid, int h);
        return 2 * n_hid * n_in + h;
    endfunction

    function automatic int vb_addr(int n_in, int n_hid, int h);
        return 2 * n_hid * n_in + n_hid + h;
    endfunction

    function automatic int ow_addr(int n_in, int n_hid, int o, int h);
        return 2 * n_hid * n_in + 2 * n_hid + o * n_hid + h;
    endfunction

    function automatic int ob_addr(int n_in, int n_hid, int n_out, int o);
        return 2 * n_hid * n_in + 2 * n_hid + n_out * n_hid + o;
    endfunction

    function automatic int w_depth(int n_in, int n_hid, int n_out);
        return 2 * n_hid * n_in + 2 * n_hid + n_out * n_hid + n_out;
    endfunction

    localparam int W_DEPTH = w_depth(9, 2, 9);

endpackage

// File: rtl/bnn_act.sv
// Combinational piecewise-linear activation: softplus (mode 0)
// or sigmoid (mode 1), shared by the hidden and output phases.
module bnn_act
    import bnn_pkg::*;
(
    input  logic                 mode,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);

    logic signed [DW-1:0] mag;
    logic signed [DW-1:0] f;

    always_comb begin
        mag = x;
        f   = HALF;
        y   = '0;
        // |SMIN| is not representable; clamp, it lands in the flat segment anyway
        if (x[DW-1]) mag = (x == SMIN) ? SMAX : -x;
        if (mag >= SG_B3)      f = ONE;
        else if (mag >= SG_B2) f = (mag >>> 5) + SG_C3;
        else if (mag >= SG_B1) f = (mag >>> 3) + SG_C2;
        else                   f = (mag >>> 2) + HALF;
        if (mode)              y = x[DW-1] ? ONE - f : f;
        else if (x <= SP_LO)   y = '0;
        else if (x < SP_HI)    y = (x >>> 2) + HALF;
        else                   y = x - ONE;
    end

endmodule

// File: rtl/bnn_mc_engine.sv
// Time-multiplexed two-layer Bayesian NN with NS Monte-Carlo
// samples, averaged sigmoid outputs streamed one per beat.
module bnn_mc_engine
    import bnn_pkg::*;
#(
    parameter int          N_IN    = 9,
    parameter int          N_HID   = 2,
    parameter int          N_OUT   = 9,
    parameter int          NS_LOG2 = 2,
    parameter logic [31:0] SEED    = 32'hACE1_2024,
    localparam int         WD      = w_depth(N_IN, N_HID, N_OUT),
    localparam int         AW      = $clog2(WD),
    localparam int         OW      = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic signed [DW-1:0] w_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [OW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 busy
);

    localparam int IW  = $clog2(N_IN);
    localparam int HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int PW  = 2 * DW;
    localparam int AVW = DW + NS_LOG2;

    state_t                  state;
    logic signed [DW-1:0]    w [WD];
    logic [N_IN-1:0]         x;
    logic [IW-1:0]           i;
    logic [HW-1:0]           h;
    logic [OW-1:0]           o;
    logic [NS_LOG2-1:0]      s;
    logic signed [DW-1:0]    acc_m, acc_v, acc_o;
    logic signed [DW-1:0]    z [N_HID];
    logic signed [AVW-1:0]   avg [N_OUT];
    logic [31:0]             lfsr;

    logic signed [DW-1:0]    wm, wv, bm, bv, wo, bo;
    logic signed [DW-1:0]    sum_m, sum_v, mean_h, v_h;
    logic signed [DW-1:0]    eps, z_next, acc_o_next;
    logic signed [DW-1:0]    act_in, act_y;
    logic signed [PW-1:0]    noise;
    logic [9:0]              slices;
    logic                    act_mode;

    function automatic logic signed [PW-1:0] sx(input logic signed [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > sx(SMAX)) return SMAX;
        if (v < sx(SMIN)) return SMIN;
        return v[DW-1:0];
    endfunction

    always_comb begin
        wm = w[AW'(mw_addr(N_IN, int'(h), int'(i)))];
        wv = w[AW'(vw_addr(N_IN, N_HID, int'(h), int'(i)))];
        bm = w[AW'(mb_addr(N_IN, N_HID, int'(h)))];
        bv = w[AW'(vb_addr(N_IN, N_HID, int'(h)))];
        wo = w[AW'(ow_addr(N_IN, N_HID, int'(o), int'(h)))];
        bo = w[AW'(ob_addr(N_IN, N_HID, N_OUT, int'(o)))];
        sum_m  = sat(sx(acc_m) + sx(wm));
        sum_v  = sat(sx(acc_v) + sx(wv));
        mean_h = sat(sx(acc_m) + sx(bm));
        v_h    = sat(sx(acc_v) + sx(bv));
        // Irwin-Hall of four bytes: mean 510, scaled to ~unit variance
        slices = 10'(lfsr[7:0]) + 10'(lfsr[15:8])
               + 10'(lfsr[23:16]) + 10'(lfsr[31:24]);
        eps    = $signed(DW'(slices) - DW'(10'd510)) <<< (FRAC - 7);
        act_mode = (state == OSIG);
        act_in   = act_mode ? sat(sx(acc_o) + sx(bo)) : v_h;
        noise  = (sx(act_y) * sx(eps)) >>> FRAC;
        z_next = sat(sx(mean_h) + noise);
        acc_o_next = sat(sx(acc_o) + ((sx(wo) * sx(z[h])) >>> FRAC));
    end

    bnn_act u_act (
        .mode (act_mode),
        .x    (act_in),
        .y    (act_y)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign out_data = out_valid ? DW'(avg[out_idx] >>> NS_LOG2) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            i         <= '0;
            h         <= '0;
            o         <= '0;
            s         <= '0;
            acc_m     <= '0;
            acc_v     <= '0;
            acc_o     <= '0;
            lfsr      <= SEED;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            for (int k = 0; k < WD; k++) w[k] <= '0;
            for (int k = 0; k < N_HID; k++) z[k] <= '0;
            for (int k = 0; k < N_OUT; k++) avg[k] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (w_we && int'(w_addr) < WD) w[w_addr] <= w_data;
                    if (in_valid) begin
                        x     <= in_x;
                        i     <= '0;
                        h     <= '0;
                        o     <= '0;
                        s     <= '0;
                        acc_m <= '0;
                        acc_v <= '0;
                        acc_o <= '0;
                        for (int k = 0; k < N_OUT; k++) avg[k] <= '0;
                        state <= HACC;
                    end
                end
                HACC: begin
                    if (x[i]) begin
                        acc_m <= sum_m;
                        acc_v <= sum_v;
                    end
                    if (i == IW'(N_IN - 1)) begin
                        i     <= '0;
                        state <= HACT;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                HACT: begin
                    z[h]  <= z_next;
                    lfsr  <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
                    acc_m <= '0;
                    acc_v <= '0;
                    if (h == HW'(N_HID - 1)) begin
                        h     <= '0;
                        o     <= '0;
                        acc_o <= '0;
                        state <= OACC;
                    end else begin
                        h     <= h + 1'b1;
                        state <= HACC;
                    end
                end
                OACC: begin
                    acc_o <= acc_o_next;
                    if (h == HW'(N_HID - 1)) begin
                        h     <= '0;
                        state <= OSIG;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
                OSIG: begin
                    avg[o] <= avg[o] + {{NS_LOG2{act_y[DW-1]}}, act_y};
                    acc_o  <= '0;
                    if (o == OW'(N_OUT - 1)) begin
                        o <= '0;
                        if (s == {NS_LOG2{1'b1}}) begin
                            out_valid <= 1'b1;
                            out_idx   <= '0;
                            out_last  <= (N_OUT == 1);
                            state     <= DRAIN;
                        end else begin
                            s     <= s + 1'b1;
                            state <= HACC;
                        end
                    end else begin
                        o     <= o + 1'b1;
                        state <= OACC;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_last <= (out_idx == OW'(N_OUT - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_mc_engine.sv
// Self-checking bench for bnn_mc_engine: fixed vectors, drain
// stall, mid-run reset and random weights against a golden model.
module tb_bnn_mc_engine;

    localparam int ONE = 65536;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic               clk;
    logic               rst_n;
    logic               w_we;
    logic [6:0]         w_addr;
    logic signed [19:0] w_data;
    logic               in_valid;
    logic               in_ready;
    logic [8:0]         in_x;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] out_data;
    logic [3:0]         out_idx;
    logic               out_last;
    logic               busy;

    bnn_mc_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          wt [67];
    int          rw [67];
    bit [31:0]   mlfsr;
    logic [19:0] exp_out [9];
    logic [19:0] got [9];
    logic [19:0] ref1 [9];
    int          lat;
    int          ncyc;
    bit          order_ok;

    typedef struct {
        logic [8:0]  x;
        int          b0, b1, b2;
        logic [19:0] e0, e1, e2;
    } vec_t;

    vec_t tbl [3];

    function automatic int a_mw(int h, int i); return h * 9 + i; endfunction
    function automatic int a_vw(int h, int i); return 18 + h * 9 + i; endfunction
    function automatic int a_mb(int h); return 36 + h; endfunction
    function automatic int a_vb(int h); return 38 + h; endfunction
    function automatic int a_ow(int o, int h); return 40 + o * 2 + h; endfunction
    function automatic int a_ob(int o); return 58 + o; endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic longint sat(longint v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    function automatic longint softplus(longint v);
        if (v <= -2 * ONE) return 0;
        if (v < 2 * ONE) return (v >>> 2) + ONE / 2;
        return v - ONE;
    endfunction

    function automatic longint sigm(longint v);
        longint a, f;
        a = (v < 0) ? -v : v;
        if (a >= 5 * ONE)              f = ONE;
        else if (a >= 19 * ONE / 8)    f = a / 32 + 27 * ONE / 32;
        else if (a >= ONE)             f = a / 8 + 5 * ONE / 8;
        else                           f = a / 4 + ONE / 2;
        return (v < 0) ? ONE - f : f;
    endfunction

    // Golden inference: loops straight over samples, neurons and inputs
    task automatic model_run(input logic [8:0] xv);
        longint avg [9];
        longint z [2];
        longint am, av, mean, sp, e, a;
        int     sl;
        for (int o = 0; o < 9; o++) avg[o] = 0;
        for (int s = 0; s < 4; s++) begin
            for (int h = 0; h < 2; h++) begin
                am = 0;
                av = 0;
                for (int i = 0; i < 9; i++) begin
                    if (xv[i]) begin
                        am = sat(am + wt[a_mw(h, i)]);
                        av = sat(av + wt[a_vw(h, i)]);
                    end
                end
                mean = sat(am + wt[a_mb(h)]);
                sp   = softplus(sat(av + wt[a_vb(h)]));
                sl   = int'(mlfsr[7:0]) + int'(mlfsr[15:8])
                     + int'(mlfsr[23:16]) + int'(mlfsr[31:24]);
                e    = longint'(sl - 510) * 512;
                z[h] = sat(mean + ((sp * e) >>> 16));
                mlfsr = {1'b0, mlfsr[31:1]} ^ (mlfsr[0] ? 32'h8020_0003 : 32'h0);
            end
            for (int o = 0; o < 9; o++) begin
                a = 0;
                for (int h = 0; h < 2; h++)
                    a = sat(a + ((longint'(wt[a_ow(o, h)]) * z[h]) >>> 16));
                avg[o] += sigm(sat(a + wt[a_ob(o)]));
            end
        end
        for (int o = 0; o < 9; o++) exp_out[o] = 20'(avg[o] >>> 2);
    endtask

    task automatic do_reset();
        w_we      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mlfsr = SEED;
        for (int k = 0; k < 67; k++) wt[k] = 0;
    endtask

    task automatic ww(int a, int d);
        w_we   = 1'b1;
        w_addr = 7'(a);
        w_data = 20'(d);
        wt[a]  = d;
        @(posedge clk);
        #1;
        w_we = 1'b0;
    endtask

    task automatic start(input logic [8:0] xv);
        in_x     = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic collect(input bit rnd);
        int n;
        n        = 0;
        ncyc     = 0;
        order_ok = 1'b1;
        while (n < 9 && ncyc < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got[n] = out_data;
                if (out_idx != 4'(n) || out_last != (n == 8)) order_ok = 1'b0;
                n++;
            end
            @(posedge clk);
            #1;
            ncyc++;
        end
        out_ready = 1'b0;
        if (n < 9) order_ok = 1'b0;
    endtask

    task automatic run(input logic [8:0] xv, input bit rnd);
        model_run(xv);
        start(xv);
        wait_valid();
        collect(rnd);
    endtask

    function automatic int rnd(int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    task automatic gen_rand(input bit fixed_var);
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 9; i++) begin
                rw[a_mw(h, i)] = rnd(3 * ONE / 2);
                rw[a_vw(h, i)] = fixed_var ? 0 : rnd(ONE);
            end
            rw[a_mb(h)] = rnd(ONE);
            rw[a_vb(h)] = fixed_var ? 3 * ONE : rnd(3 * ONE);
        end
        for (int o = 0; o < 9; o++) begin
            for (int h = 0; h < 2; h++) rw[a_ow(o, h)] = rnd(2 * ONE);
            rw[a_ob(o)] = rnd(ONE);
        end
    endtask

    task automatic load_rw();
        for (int k = 0; k < 67; k++) ww(k, rw[k]);
    endtask

    initial begin
        logic [19:0] d0;
        logic [3:0]  i0;
        logic        l0;
        bit          stable;
        logic [8:0]  xr;

        tbl[0] = '{9'h155, 0, 0, 0, 20'h08000, 20'h08000, 20'h08000};
        tbl[1] = '{9'h0AA, 6 * ONE, -6 * ONE, 3 * ONE / 2,
                   20'h10000, 20'h00000, 20'h0D000};
        tbl[2] = '{9'h1FF, ONE / 2, -ONE, 3 * ONE,
                   20'h0A000, 20'h04000, 20'h0F000};

        w_addr = '0;
        w_data = '0;
        in_x   = '0;
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);

        for (int t = 0; t < 3; t++) begin
            ww(a_ob(0), tbl[t].b0);
            ww(a_ob(1), tbl[t].b1);
            ww(a_ob(2), tbl[t].b2);
            run(tbl[t].x, 1'b0);
            chk($sformatf("tbl%0d_latency", t), 32'(lat), 188);
            chk($sformatf("tbl%0d_order", t), 32'(order_ok), 1);
            for (int k = 0; k < 9; k++)
                chk($sformatf("tbl%0d_beat%0d", t, k), 32'(got[k]),
                    32'((k == 0) ? tbl[t].e0 : (k == 1) ? tbl[t].e1 :
                        (k == 2) ? tbl[t].e2 : 20'h08000));
        end

        // sp forced to 0 so z0 is exactly 1.0 regardless of noise
        for (int o = 0; o < 3; o++) ww(a_ob(o), 0);
        ww(a_vb(0), -8 * ONE);
        ww(a_vb(1), -8 * ONE);
        ww(a_mw(0, 8), ONE);
        ww(a_ow(0, 0), ONE);
        for (int r = 0; r < 2; r++) begin
            run(9'h100, 1'b1);
            chk($sformatf("det%0d_out0", r), 32'(got[0]), 32'h0C000);
            chk($sformatf("det%0d_out5", r), 32'(got[5]), 32'h08000);
            chk($sformatf("det%0d_order", r), 32'(order_ok), 1);
        end

        model_run(9'h100);
        start(9'h100);
        wait_valid();
        chk("stall_reach_drain", 32'(out_valid), 1);
        d0     = out_data;
        i0     = out_idx;
        l0     = out_last;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                w_we   = 1'b1;
                w_addr = 7'(a_ob(0));
                w_data = 20'(6 * ONE);
            end
            if (c == 11) w_we = 1'b0;
            if (out_data !== d0 || out_idx !== i0 || out_last !== l0 ||
                !out_valid || in_ready) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        w_we = 1'b0;
        chk("stall_stable", 32'(stable), 1);
        collect(1'b0);
        chk("stall_consecutive", 32'(ncyc), 9);
        chk("stall_order", 32'(order_ok), 1);
        chk("stall_out0", 32'(got[0]), 32'h0C000);
        chk("b2b_in_ready", 32'(in_ready), 1);
        run(9'h100, 1'b0);
        chk("drain_write_dropped", 32'(got[0]), 32'h0C000);

        do_reset();
        gen_rand(1'b0);
        load_rw();
        run(9'h0F3, 1'b0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("fresh_beat%0d", k), 32'(got[k]), 32'(exp_out[k]));
            ref1[k] = got[k];
        end
        do_reset();
        load_rw();
        start(9'h0F3);
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        do_reset();
        load_rw();
        run(9'h0F3, 1'b0);
        for (int k = 0; k < 9; k++)
            chk($sformatf("rerun_beat%0d", k), 32'(got[k]), 32'(ref1[k]));

        do_reset();
        run(9'h1FF, 1'b0);
        for (int k = 0; k < 9; k++)
            chk($sformatf("wzero_beat%0d", k), 32'(got[k]), 32'h08000);

        do_reset();
        gen_rand(1'b1);
        load_rw();
        for (int r = 0; r < 3; r++) begin
            xr = 9'($urandom);
            run(xr, 1'b1);
            chk($sformatf("rand%0d_order", r), 32'(order_ok), 1);
            for (int k = 0; k < 9; k++)
                chk($sformatf("rand%0d_beat%0d", r, k), 32'(got[k]),
                    32'(exp_out[k]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_mc_engine.md
# bnn_mc_engine

Time-multiplexed, parametrised Bayesian neural network inference engine for the two-layer classifier. Per hidden neuron it computes a mean and a variance pre-activation over binary inputs, then draws z = mean + softplus(var)·ε with an on-chip Gaussian-approximate ε. It runs NS Monte-Carlo samples through a sigmoid output layer and averages them. Weights are loaded through a write port, and results stream out one output per handshake beat.

## Interface
- N_IN, 9, binary input count
- N_HID, 2, hidden (stochastic) neurons
- N_OUT, 9, output neurons
- DW, 20, signed fixed-point data width
- FRAC, 16, fractional bits (1.0 = 0x10000)
- NS_LOG2, 2, log2 of Monte-Carlo sample count (NS = 4)
- SEED, 32'hACE1_2024, LFSR reset value (nonzero)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(W_DEPTH)  weight address (map in package)
- w_data  in  DW  signed weight/bias
- in_valid  in  1  input vector valid
- in_ready  out  1  high only in IDLE
- in_x  in  N_IN  binary input vector, bit i = input i
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DW  averaged sigmoid output, Q(FRAC)
- out_idx  out  $clog2(N_OUT)  output index of beat
- out_last  out  1  high on beat N_OUT−1
- busy  out  1  state ≠ IDLE

## Operation
- Weight map, in order: mean W[h][i], var W[h][i], mean bias[h], var bias[h], output W[o][h], output bias[o].
- w_we takes effect only in IDLE. Writes in any other state are dropped. Out-of-range addresses are ignored.
- Input accept: an in_valid && in_ready cycle latches in_x, clears the average accumulators and goes to HACC with s=h=i=0.
- HACC: one input per cycle. If x[i]=1, the mean and var accumulators add their weights. After i=N_IN−1 go to HACT.
- HACT, one cycle:
  - mean_h = accm + bias; v = accv + bias.
  - softplus is a 3-segment PLA: v ≤ −2 → 0; −2 < v < 2 → v/4 + 0.5; v ≥ 2 → v − 1.
  - z_h = mean_h + (sp·ε) >>> FRAC, saturated to DW. Advance the LFSR.
  - Next hidden neuron, or go to OACC when h = N_HID−1.
- ε: 32-bit Galois LFSR, polynomial 0x80200003. ε = (Σ four 8-bit slices − 510) << (FRAC−7).
- OACC: N_HID cycles, a = Σ W[o][h]·z_h >>> FRAC.
- OSIG, one cycle:
  - Add the bias and apply the PLAN sigmoid on |x|: ≥5 → 1; [2.375,5) → |x|/32 + 0.84375; [1,2.375) → |x|/8 + 0.625; [0,1) → |x|/4 + 0.5.
  - For negative x the result is 1 − f.
  - Add into avg[o], which is DW+NS_LOG2 bits wide.
  - Next output; after o = N_OUT−1 start the next sample, or go to DRAIN when s = NS−1.
- DRAIN: out_data = avg[out_idx] >>> NS_LOG2. The beat advances on out_valid && out_ready. The last beat returns to IDLE.
- All intermediate arithmetic uses 2·DW-bit products with truncating arithmetic right shift, then saturates to DW.

## Timing
- Reset values: state IDLE, in_ready 1, busy 0, out_valid 0, out_data 0, out_idx 0, out_last 0, all weights 0, accumulators 0, LFSR = SEED.
- Compute latency from the accept cycle to the first out_valid: NS·(N_HID·(N_IN+1) + N_OUT·(N_HID+1)) cycles. The default is 188.
- During DRAIN, out_data, out_idx and out_last are stable while out_ready is low.
- Back-to-back operation: in_ready rises the cycle after the last beat is taken.
- in_valid outside IDLE is ignored, and no input is queued.
- The LFSR is not reset between inferences. Its sequence depends only on SEED and the inference count since reset.
- Reset mid-operation aborts immediately:
  - Partial accumulators are discarded.
  - No out_valid is asserted.
  - Weights return to 0.

## Structure
- Package bnn_pkg holds:
  - the state enum (IDLE, HACC, HACT, OACC, OSIG, DRAIN);
  - weight-map offset functions and W_DEPTH;
  - the Q-format constants ONE, HALF and the PLA breakpoints;
  - the LFSR polynomial.
- Sub-module bnn_act holds the combinational softplus and sigmoid PLA, selected by a mode bit. It is reused for both activations.

## Test plan
- All weights 0, any in_x → 9 beats of out_data 0x08000, out_idx 0..8, out_last on idx 8. First out_valid 188 cycles after accept.
- Output bias[0] = +6.0, bias[1] = −6.0, bias[2] = +1.5, all else 0 → beats 0x10000, 0x00000, 0x0D000.
- Var bias −8.0 (sp = 0), mean W[0][8] = 1.0, output W[0][0] = 1.0, in_x = 9'h100 → out 0 = sigmoid(1.0) = 0x0C000, deterministic across repeated runs.
- out_ready held low for 50 cycles in DRAIN → outputs stable, in_ready 0. Releasing it yields 9 consecutive beats. A w_we issued in DRAIN has no effect.
- Assert rst_n low during OACC, then rerun the same vector → results bit-identical to a fresh post-reset run.
- Var bias 3.0 (sp = 2.0), random weights, three consecutive inferences → match the golden model seeded with SEED bit-exactly.
